vga_overlay_compositor: RTL and testbench

- Generates per-pixel colour for the VGA timing core from the next-pixel coordinate stream.
- Renders a configurable background pattern plus a fixed-position gradient palette bar framed by a black gap and a border ring.
- Configuration arrives on a valid/ready write port into shadow registers and commits to active registers only at end-of-frame, so there is no mid-frame tearing.
- Output is pipelined (2 cycles) and replaces the single-colour GPIO pixel source.

---
 rtl/vga_overlay_pkg.sv | 21 ++
 rtl/vga_overlay_cfg_regs.sv | 71 +++++++
 rtl/vga_overlay_compositor.sv | 170 +++++++++++++++++
 tb/tb_vga_overlay_compositor.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_overlay_pkg.sv
// rtl/vga_overlay_pkg.sv - shared encodings and reset defaults for the VGA overlay compositor
package vga_overlay_pkg;

   typedef enum logic [1:0] {
      MODE_SOLID     = 2'd0,
      MODE_SOLID_ALT = 2'd1,
      MODE_CHECKER   = 2'd2,
      MODE_BARS      = 2'd3
   } mode_e;

   localparam logic [1:0] CFG_ADDR_BG     = 2'd0;
   localparam logic [1:0] CFG_ADDR_MODE   = 2'd1;
   localparam logic [1:0] CFG_ADDR_BORDER = 2'd2;
   localparam logic [1:0] CFG_ADDR_CTRL   = 2'd3;

   // Background resets to all zeros and border to all ones; both are
   // width-dependent so they are applied as '0 / '1 at the register.
   localparam mode_e RST_MODE   = MODE_SOLID_ALT;
   localparam logic  RST_BAR_EN = 1'b1;

endpackage

// File: rtl/vga_overlay_cfg_regs.sv
// rtl/vga_overlay_cfg_regs.sv - shadow/active configuration registers committed at end of frame
module vga_overlay_cfg_regs #(
   parameter int NUM_COLOR_BITS = 16
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic                      i_eof,
   input  logic                      i_cfg_valid,
   output logic                      o_cfg_ready,
   input  logic [1:0]                i_cfg_addr,
   input  logic [NUM_COLOR_BITS-1:0] i_cfg_data,
   output logic [NUM_COLOR_BITS-1:0] o_bg,
   output logic [NUM_COLOR_BITS-1:0] o_border,
   output logic [1:0]                o_mode,
   output logic                      o_bar_en
);
   import vga_overlay_pkg::*;

   logic [NUM_COLOR_BITS-1:0] r_sh_bg;
   logic [NUM_COLOR_BITS-1:0] r_sh_border;
   mode_e                     r_sh_mode;
   logic                      r_sh_bar_en;
   logic [NUM_COLOR_BITS-1:0] r_act_bg;
   logic [NUM_COLOR_BITS-1:0] r_act_border;
   mode_e                     r_act_mode;
   logic                      r_act_bar_en;
   logic                      r_pending;
   logic                      w_accept;

   // Writes are held off during the commit cycle so a write can never race the copy.
   assign o_cfg_ready = !i_eof;
   assign w_accept    = i_cfg_valid && o_cfg_ready;

   // Shadow capture on accepted writes; shadow-to-active copy on end of frame when pending.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_sh_bg      <= '0;
         r_sh_border  <= '1;
         r_sh_mode    <= RST_MODE;
         r_sh_bar_en  <= RST_BAR_EN;
         r_act_bg     <= '0;
         r_act_border <= '1;
         r_act_mode   <= RST_MODE;
         r_act_bar_en <= RST_BAR_EN;
         r_pending    <= 1'b0;
      end else begin
         if (w_accept) begin
            case (i_cfg_addr)
               CFG_ADDR_BG:     r_sh_bg     <= i_cfg_data;
               CFG_ADDR_MODE:   r_sh_mode   <= mode_e'(i_cfg_data[1:0]);
               CFG_ADDR_BORDER: r_sh_border <= i_cfg_data;
               default:         r_sh_bar_en <= i_cfg_data[0];
            endcase
            r_pending <= 1'b1;
         end
         if (i_eof && r_pending) begin
            r_act_bg     <= r_sh_bg;
            r_act_border <= r_sh_border;
            r_act_mode   <= r_sh_mode;
            r_act_bar_en <= r_sh_bar_en;
            r_pending    <= 1'b0;
         end
      end
   end

   assign o_bg     = r_act_bg;
   assign o_border = r_act_border;
   assign o_mode   = r_act_mode;
   assign o_bar_en = r_act_bar_en;

endmodule

// File: rtl/vga_overlay_compositor.sv
// rtl/vga_overlay_compositor.sv - two-stage pixel compositor (optional border blink: VGA_OVERLAY_BLINK_EN)
module vga_overlay_compositor #(
   parameter int R_BITS         = 5,
   parameter int G_BITS         = 6,
   parameter int B_BITS         = 5,
   parameter int NUM_COLOR_BITS = R_BITS + G_BITS + B_BITS,
   parameter int COORD_W        = 12,
   parameter int V_ACTIVE       = 1080,
   parameter int BAR_LEFT       = 448,
   parameter int BAR_WIDTH      = 1024,
   parameter int BAR_HEIGHT     = 128,
   parameter int BORDER_W       = 1
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic                      eof_flag,
   input  logic [COORD_W-1:0]        n_pixel_x,
   input  logic [COORD_W-1:0]        n_pixel_y,
   input  logic                      n_pixel_valid,
   output logic [NUM_COLOR_BITS-1:0] n_pixel_color,
   output logic                      n_pixel_color_valid,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [1:0]                cfg_addr,
   input  logic [NUM_COLOR_BITS-1:0] cfg_data,
   output logic [7:0]                frame_cnt
);
   import vga_overlay_pkg::*;

   localparam int IDX_MSB = $clog2(BAR_WIDTH) - 1;

   // Ring origins wrap at COORD_W bits so a bar touching column 0 clips its ring.
   localparam logic [COORD_W-1:0] X_BAR0 = COORD_W'(BAR_LEFT);
   localparam logic [COORD_W-1:0] X_GAP0 = COORD_W'(BAR_LEFT - 1);
   localparam logic [COORD_W-1:0] X_BDR0 = COORD_W'(BAR_LEFT - 1 - BORDER_W);
   localparam logic [31:0] W_BAR = 32'(BAR_WIDTH);
   localparam logic [31:0] W_GAP = 32'(BAR_WIDTH + 2);
   localparam logic [31:0] W_BDR = 32'(BAR_WIDTH + 2 + 2 * BORDER_W);
   localparam logic [31:0] Y_BAR = 32'(V_ACTIVE - BAR_HEIGHT);
   localparam logic [31:0] Y_GAP_OFS = 32'd1;
   localparam logic [31:0] Y_BDR_OFS = 32'(1 + BORDER_W);

   function automatic logic [NUM_COLOR_BITS-1:0] expand_idx(input logic [2:0] idx);
      return {{R_BITS{idx[2]}}, {G_BITS{idx[1]}}, {B_BITS{idx[0]}}};
   endfunction

   logic [NUM_COLOR_BITS-1:0] w_bg;
   logic [NUM_COLOR_BITS-1:0] w_border;
   logic [1:0]                w_mode;
   logic                      w_bar_en;

   vga_overlay_cfg_regs #(
      .NUM_COLOR_BITS(NUM_COLOR_BITS)
   ) u_cfg_regs (
      .clk        (clk),
      .aresetn    (aresetn),
      .i_eof      (eof_flag),
      .i_cfg_valid(cfg_valid),
      .o_cfg_ready(cfg_ready),
      .i_cfg_addr (cfg_addr),
      .i_cfg_data (cfg_data),
      .o_bg       (w_bg),
      .o_border   (w_border),
      .o_mode     (w_mode),
      .o_bar_en   (w_bar_en)
   );

   logic [COORD_W-1:0] w_dx;
   logic [COORD_W-1:0] w_dx_gap;
   logic [COORD_W-1:0] w_dx_bdr;
   logic               w_in_bar;
   logic               w_inner_ring;
   logic               w_in_gap;
   logic               w_in_border;

   assign w_dx     = n_pixel_x - X_BAR0;
   assign w_dx_gap = n_pixel_x - X_GAP0;
   assign w_dx_bdr = n_pixel_x - X_BDR0;

   // Each region is a nested rectangle anchored to the bottom edge; inner ones are carved out.
   assign w_in_bar     = (32'(n_pixel_y) >= Y_BAR) && (32'(w_dx) < W_BAR);
   assign w_inner_ring = (32'(n_pixel_y) + Y_GAP_OFS >= Y_BAR) && (32'(w_dx_gap) < W_GAP);
   assign w_in_gap     = w_inner_ring && !w_in_bar;
   assign w_in_border  = (32'(n_pixel_y) + Y_BDR_OFS >= Y_BAR) && (32'(w_dx_bdr) < W_BDR)
                         && !w_inner_ring;

   logic       r_s1_valid;
   logic       r_s1_in_bar;
   logic       r_s1_in_gap;
   logic       r_s1_in_border;
   logic [2:0] r_s1_bar_idx;
   logic [2:0] r_s1_col_idx;
   logic       r_s1_checker;

   // Stage 1: register the region classification and both gradient indices.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_s1_valid     <= 1'b0;
         r_s1_in_bar    <= 1'b0;
         r_s1_in_gap    <= 1'b0;
         r_s1_in_border <= 1'b0;
         r_s1_bar_idx   <= '0;
         r_s1_col_idx   <= '0;
         r_s1_checker   <= 1'b0;
      end else begin
         r_s1_valid     <= n_pixel_valid;
         r_s1_in_bar    <= w_in_bar;
         r_s1_in_gap    <= w_in_gap;
         r_s1_in_border <= w_in_border;
         r_s1_bar_idx   <= w_dx[IDX_MSB -: 3];
         r_s1_col_idx   <= n_pixel_x[COORD_W-1 -: 3];
         r_s1_checker   <= n_pixel_x[5] ^ n_pixel_y[5];
      end
   end

   logic [7:0] r_frame_cnt;
   logic       w_ring_on;

`ifdef VGA_OVERLAY_BLINK_EN
   assign w_ring_on = !r_frame_cnt[5];
`else
   assign w_ring_on = 1'b1;
`endif

   logic [NUM_COLOR_BITS-1:0] w_mode_color;
   logic [NUM_COLOR_BITS-1:0] w_color;

   // Stage 2 colour select: bar, gap and border override the background mode content.
   always_comb begin
      w_mode_color = w_bg;
      case (mode_e'(w_mode))
         MODE_CHECKER: w_mode_color = r_s1_checker ? w_border : w_bg;
         MODE_BARS:    w_mode_color = expand_idx(r_s1_col_idx);
         default:      w_mode_color = w_bg;
      endcase
      w_color = '0;
      if (!r_s1_valid)
         w_color = '0;
      else if (w_bar_en && r_s1_in_bar)
         w_color = expand_idx(r_s1_bar_idx);
      else if (w_bar_en && r_s1_in_gap)
         w_color = '0;
      else if (w_bar_en && r_s1_in_border && w_ring_on)
         w_color = w_border;
      else
         w_color = w_mode_color;
   end

   // Stage 2: register the final colour and its qualifier.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         n_pixel_color       <= '0;
         n_pixel_color_valid <= 1'b0;
      end else begin
         n_pixel_color       <= w_color;
         n_pixel_color_valid <= r_s1_valid;
      end
   end

   // Frame counter advances on every end-of-frame pulse, independent of commits.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         r_frame_cnt <= '0;
      else if (eof_flag)
         r_frame_cnt <= r_frame_cnt + 8'd1;
   end

   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_overlay_compositor.sv
// tb/tb_vga_overlay_compositor.sv - self-checking bench for vga_overlay_compositor
module tb_vga_overlay_compositor;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        eof_flag = 1'b0;
   logic [11:0] n_pixel_x = '0;
   logic [11:0] n_pixel_y = '0;
   logic        n_pixel_valid = 1'b0;
   logic [15:0] n_pixel_color;
   logic        n_pixel_color_valid;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic [7:0]  frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   vga_overlay_compositor dut (
      .clk                (clk),
      .aresetn            (aresetn),
      .eof_flag           (eof_flag),
      .n_pixel_x          (n_pixel_x),
      .n_pixel_y          (n_pixel_y),
      .n_pixel_valid      (n_pixel_valid),
      .n_pixel_color      (n_pixel_color),
      .n_pixel_color_valid(n_pixel_color_valid),
      .cfg_valid          (cfg_valid),
      .cfg_ready          (cfg_ready),
      .cfg_addr           (cfg_addr),
      .cfg_data           (cfg_data),
      .frame_cnt          (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input int x, input int y, input bit v);
      n_pixel_x = 12'(x);
      n_pixel_y = 12'(y);
      n_pixel_valid = v;
      tick();
      tick();
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_addr = a;
      cfg_data = d;
      cfg_valid = 1'b1;
      #1;
      check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic eof_pulse();
      eof_flag = 1'b1;
      tick();
      eof_flag = 1'b0;
   endtask

   task automatic do_reset();
      eof_flag = 1'b0;
      cfg_valid = 1'b0;
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
   endtask

   function automatic logic [15:0] rep(input int i);
      return (((i & 4) != 0) ? 16'hF800 : 16'h0000) |
             (((i & 2) != 0) ? 16'h07E0 : 16'h0000) |
             (((i & 1) != 0) ? 16'h001F : 16'h0000);
   endfunction

   // Reference colour for the default geometry: bar rows 952..1079, columns 448..1471.
   function automatic logic [15:0] color_of(input int x, input int y, input bit v,
                                            input logic [15:0] bg, input int mode,
                                            input logic [15:0] bd, input bit en, input int fc);
      bit in_bar, in_gap, in_bdr, ring_on;
      logic [15:0] content;
      if (!v) return 16'h0000;
      in_bar = (y >= 952) && (x >= 448) && (x < 1472);
      in_gap = !in_bar && (y >= 951) && (x >= 447) && (x <= 1472);
      in_bdr = !in_bar && !in_gap && (y >= 950) && (x >= 446) && (x <= 1473);
`ifdef VGA_OVERLAY_BLINK_EN
      ring_on = ((fc / 32) % 2) == 0;
`else
      ring_on = (fc >= 0);
`endif
      if (mode == 2)
         content = (((x / 32) % 2) != ((y / 32) % 2)) ? bd : bg;
      else if (mode == 3)
         content = rep(x / 512);
      else
         content = bg;
      if (en && in_bar) return rep((x - 448) / 128);
      if (en && in_gap) return 16'h0000;
      if (en && in_bdr && ring_on) return bd;
      return content;
   endfunction

   typedef struct {
      int          x;
      int          y;
      bit          v;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[18];

   initial begin
      logic [15:0] m_bg, m_bd, s_bg, s_bd, exp_c;
      int m_mode, s_mode, m_fc, px, py, cx, cy;
      bit m_en, s_en, m_pend, pv, cv, exp_v, ce, cval;
      logic [1:0] ca;
      logic [15:0] cd;

      vecs[0]  = '{500, 1000, 1'b1, 16'h0000};
      vecs[1]  = '{576, 1000, 1'b1, 16'h001F};
      vecs[2]  = '{447, 1079, 1'b1, 16'h0000};
      vecs[3]  = '{446, 1079, 1'b1, 16'hFFFF};
      vecs[4]  = '{1471, 1079, 1'b1, 16'hFFFF};
      vecs[5]  = '{1472, 1079, 1'b1, 16'h0000};
      vecs[6]  = '{1473, 1079, 1'b1, 16'hFFFF};
      vecs[7]  = '{1474, 1079, 1'b1, 16'h0000};
      vecs[8]  = '{600, 950, 1'b1, 16'hFFFF};
      vecs[9]  = '{600, 951, 1'b1, 16'h0000};
      vecs[10] = '{600, 952, 1'b1, 16'h001F};
      vecs[11] = '{600, 949, 1'b1, 16'h0000};
      vecs[12] = '{1000, 1000, 1'b0, 16'h0000};
      vecs[13] = '{448, 1000, 1'b1, 16'h0000};
      vecs[14] = '{831, 1000, 1'b1, 16'h07E0};
      vecs[15] = '{1200, 1000, 1'b1, 16'hF81F};
      vecs[16] = '{1000, 1000, 1'b1, 16'hF800};
      vecs[17] = '{1300, 1000, 1'b1, 16'hFFE0};

      // Asynchronous reset asserted mid-stream clears the output without a clock edge.
      do_reset();
      pixel(576, 1000, 1'b1);
      check("pre_reset_color", 32'(n_pixel_color), 32'h001F);
      n_pixel_x = 12'd500;
      n_pixel_y = 12'd1000;
      aresetn = 1'b0;
      #1;
      check("reset_color", 32'(n_pixel_color), 32'h0);
      check("reset_valid", 32'(n_pixel_color_valid), 32'd0);
      check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      tick();
      aresetn = 1'b1;
      pixel(500, 1000, 1'b1);
      check("post_reset_color", 32'(n_pixel_color), 32'h0000);
      check("post_reset_valid", 32'(n_pixel_color_valid), 32'd1);

      for (int i = 0; i < 18; i++) begin
         pixel(vecs[i].x, vecs[i].y, vecs[i].v);
         check($sformatf("vec%0d_color", i), 32'(n_pixel_color), 32'(vecs[i].exp));
         check($sformatf("vec%0d_valid", i), 32'(n_pixel_color_valid), 32'(vecs[i].v));
      end

      // A shadow write becomes visible only after the next end of frame.
      cfg_write(2'd0, 16'hF800);
      pixel(10, 10, 1'b1);
      check("commit_before_eof", 32'(n_pixel_color), 32'h0000);
      eof_pulse();
      pixel(10, 10, 1'b1);
      check("commit_after_eof", 32'(n_pixel_color), 32'hF800);

      // Write offered during end of frame is refused; the next-cycle write waits a frame.
      eof_flag = 1'b1;
      cfg_valid = 1'b1;
      cfg_addr = 2'd0;
      cfg_data = 16'h1234;
      #1;
      check("collision_ready_low", 32'(cfg_ready), 32'd0);
      @(posedge clk);
      #1;
      eof_flag = 1'b0;
      cfg_data = 16'h001F;
      #1;
      check("collision_ready_high", 32'(cfg_ready), 32'd1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      pixel(10, 10, 1'b1);
      check("collision_not_yet", 32'(n_pixel_color), 32'hF800);
      eof_pulse();
      pixel(10, 10, 1'b1);
      check("collision_committed", 32'(n_pixel_color), 32'h001F);
      eof_flag = 1'b1;
      cfg_valid = 1'b1;
      cfg_data = 16'h1234;
      tick();
      eof_flag = 1'b0;
      cfg_valid = 1'b0;
      eof_pulse();
      pixel(10, 10, 1'b1);
      check("refused_write_dropped", 32'(n_pixel_color), 32'h001F);

      // Background modes and bar disable.
      cfg_write(2'd1, 16'd2);
      cfg_write(2'd0, 16'h0000);
      cfg_write(2'd2, 16'h07E0);
      eof_pulse();
      pixel(0, 0, 1'b1);
      check("checker_x0", 32'(n_pixel_color), 32'h0000);
      pixel(32, 0, 1'b1);
      check("checker_x32", 32'(n_pixel_color), 32'h07E0);
      pixel(32, 32, 1'b1);
      check("checker_x32_y32", 32'(n_pixel_color), 32'h0000);
      cfg_write(2'd1, 16'd3);
      eof_pulse();
      pixel(0, 0, 1'b1);
      check("bars_x0", 32'(n_pixel_color), 32'h0000);
      pixel(512, 0, 1'b1);
      check("bars_x512", 32'(n_pixel_color), 32'h001F);
      pixel(446, 1079, 1'b1);
      check("bars_border_enabled", 32'(n_pixel_color), 32'h07E0);
      cfg_write(2'd3, 16'd0);
      eof_pulse();
      pixel(1100, 1000, 1'b1);
      check("bar_disabled", 32'(n_pixel_color), 32'h07E0);
      pixel(446, 1079, 1'b1);
      check("bar_disabled_border", 32'(n_pixel_color), 32'h0000);

      // Frame counter, border blink phase and wrap.
      do_reset();
      check("fc_reset", 32'(frame_cnt), 32'd0);
      for (int i = 0; i < 32; i++) eof_pulse();
      check("fc_32", 32'(frame_cnt), 32'd32);
      pixel(446, 1079, 1'b1);
`ifdef VGA_OVERLAY_BLINK_EN
      check("blink_off", 32'(n_pixel_color), 32'h0000);
`else
      check("blink_off", 32'(n_pixel_color), 32'hFFFF);
`endif
      pixel(447, 1079, 1'b1);
      check("blink_gap", 32'(n_pixel_color), 32'h0000);
      for (int i = 0; i < 32; i++) eof_pulse();
      pixel(446, 1079, 1'b1);
      check("blink_on", 32'(n_pixel_color), 32'hFFFF);
      for (int i = 0; i < 191; i++) eof_pulse();
      check("fc_255", 32'(frame_cnt), 32'd255);
      eof_pulse();
      check("fc_wrap", 32'(frame_cnt), 32'd0);

      // Randomised traffic against the reference model.
      do_reset();
      m_bg = 16'h0000; m_bd = 16'hFFFF; m_mode = 1; m_en = 1'b1;
      s_bg = m_bg; s_bd = m_bd; s_mode = m_mode; s_en = m_en;
      m_pend = 1'b0; m_fc = 0;
      px = 0; py = 0; pv = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         cx = $urandom_range(0, 1919);
         cy = ($urandom_range(0, 1) == 1) ? $urandom_range(940, 1079) : $urandom_range(0, 1079);
         cval = ($urandom_range(0, 7) != 0);
         ce = ($urandom_range(0, 39) == 0);
         cv = ($urandom_range(0, 5) == 0);
         ca = 2'($urandom_range(0, 3));
         cd = 16'($urandom);
         n_pixel_x = 12'(cx);
         n_pixel_y = 12'(cy);
         n_pixel_valid = cval;
         eof_flag = ce;
         cfg_valid = cv;
         cfg_addr = ca;
         cfg_data = cd;
         #1;
         check("rand_cfg_ready", 32'(cfg_ready), 32'(!ce));
         @(posedge clk);
         exp_c = color_of(px, py, pv, m_bg, m_mode, m_bd, m_en, m_fc);
         exp_v = pv;
         if (cv && !ce) begin
            case (ca)
               2'd0: s_bg = cd;
               2'd1: s_mode = int'(cd[1:0]);
               2'd2: s_bd = cd;
               default: s_en = cd[0];
            endcase
            m_pend = 1'b1;
         end
         if (ce) begin
            m_fc = (m_fc + 1) % 256;
            if (m_pend) begin
               m_bg = s_bg; m_bd = s_bd; m_mode = s_mode; m_en = s_en;
               m_pend = 1'b0;
            end
         end
         px = cx; py = cy; pv = cval;
         #1;
         check("rand_color", 32'(n_pixel_color), 32'(exp_c));
         check("rand_valid", 32'(n_pixel_color_valid), 32'(exp_v));
         check("rand_frame_cnt", 32'(frame_cnt), 32'(m_fc));
      end
      eof_flag = 1'b0;
      cfg_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
